// File: rtl/uart_modport.sv
// uart_modport: Wishbone slave UART with a 16550-style register map, a 16x baud generator and one-byte TX/RX holding registers.
// Define UART_LOOPBACK_EN to compile in the internal MCR[4] loopback path.
module uart_modport (
   input  logic       clock,
   input  logic       wb_rst_i,
   input  logic [3:0] wb_addr_i,
   input  logic [3:0] wb_sel_i,
   input  logic [7:0] wb_dat_i,
   input  logic       wb_we_i,
   input  logic       wb_stb_i,
   input  logic       wb_cyc_i,
   output logic [7:0] wb_dat_o,
   output logic       wb_ack_o,
   output logic       int_o,
   output logic       baud_o,
   input  logic       srx_pad_i,
   output logic       stx_pad_o
);
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} ser_t;

   logic        r_ack;
   logic [7:0]  r_dat;
   logic [7:0]  r_dll, r_dlm, r_ier, r_lcr, r_mcr, r_scr, r_rbr, r_thr, r_iir, r_lsr;
   logic        r_thre, r_pend, r_dr, r_oe, r_pe, r_fe, r_int;
   logic [15:0] r_bcnt;
   logic        r_baud;
   ser_t        r_tx_st, w_tx_nxt;
   logic [7:0]  r_tx_shr;
   logic [3:0]  r_tx_tick;
   logic [2:0]  r_tx_bit;
   logic        r_tx_par, r_stx;
   ser_t        r_rx_st, w_rx_nxt;
   logic        r_rx_s1, r_rx_s2, r_rx_s3;
   logic [7:0]  r_rx_shr;
   logic [3:0]  r_rx_tick;
   logic [2:0]  r_rx_bit;
   logic        r_rx_par;

   logic        w_req, w_acc, w_wr, w_rd, w_dlab;
   logic        w_rbr_rd, w_lsr_rd, w_iir_rd, w_thr_wr;
   logic [2:0]  w_last;
   logic [15:0] w_div;
   logic        w_temt, w_tx_load, w_tx_bend, w_tx_ser, w_thr_par;
   logic [7:0]  w_tx_mask;
   logic        w_loop, w_rx_in, w_rx_smp, w_rx_done, w_par_exp;
   logic [7:0]  w_rx_data, w_rdata, w_iir, w_lsr;

   assign w_req    = wb_cyc_i & wb_stb_i & ~r_ack;
   assign w_acc    = w_req & (|wb_sel_i) & ~wb_addr_i[3];
   assign w_wr     = w_acc & wb_we_i;
   assign w_rd     = w_acc & ~wb_we_i;
   assign w_dlab   = r_lcr[7];
   assign w_rbr_rd = w_rd & (wb_addr_i[2:0] == 3'd0) & ~w_dlab;
   assign w_iir_rd = w_rd & (wb_addr_i[2:0] == 3'd2);
   assign w_lsr_rd = w_rd & (wb_addr_i[2:0] == 3'd5);
   assign w_thr_wr = w_wr & (wb_addr_i[2:0] == 3'd0) & ~w_dlab;

   assign w_last    = {1'b0, r_lcr[1:0]} + 3'd4;
   assign w_div     = {r_dlm, r_dll};
   assign w_temt    = r_thre & (r_tx_st == S_IDLE);
   assign w_tx_load = (r_tx_st == S_IDLE) & ~r_thre;
   assign w_tx_bend = r_baud & (r_tx_tick == 4'hF);
   assign w_tx_mask = 8'hFF >> (2'd3 - r_lcr[1:0]);
   assign w_thr_par = r_lcr[4] ? ^(r_thr & w_tx_mask) : ~^(r_thr & w_tx_mask);

`ifdef UART_LOOPBACK_EN
   assign w_loop = r_mcr[4];
`else
   assign w_loop = 1'b0;
`endif
   assign w_rx_in = w_loop ? w_tx_ser : srx_pad_i;

   // Start bit is checked at mid-bit (8 ticks), later bits every 16 ticks
   assign w_rx_smp  = r_baud & (r_rx_tick == ((r_rx_st == S_START) ? 4'd7 : 4'd15));
   assign w_rx_done = (r_rx_st == S_STOP) & w_rx_smp;
   assign w_rx_data = r_rx_shr >> (2'd3 - r_lcr[1:0]);
   assign w_par_exp = r_lcr[4] ? ^w_rx_data : ~^w_rx_data;

   assign w_lsr = {1'b0, w_temt, r_thre, 1'b0, r_fe, r_pe, r_oe, r_dr};

   always_comb begin
      w_iir = 8'h01;
      if (r_ier[2] & (r_oe | r_pe | r_fe)) w_iir = 8'h06;
      else if (r_ier[0] & r_dr)            w_iir = 8'h04;
      else if (r_ier[1] & r_pend)          w_iir = 8'h02;
   end

   always_comb begin
      w_rdata = '0;
      if (w_rd) begin
         case (wb_addr_i[2:0])
            3'd0:    w_rdata = w_dlab ? r_dll : r_rbr;
            3'd1:    w_rdata = w_dlab ? r_dlm : r_ier;
            3'd2:    w_rdata = r_iir;
            3'd3:    w_rdata = r_lcr;
            3'd4:    w_rdata = r_mcr;
            3'd5:    w_rdata = r_lsr;
            3'd7:    w_rdata = r_scr;
            default: w_rdata = '0;
         endcase
      end
   end

   always_ff @(posedge clock or negedge wb_rst_i) begin
      if (!wb_rst_i) begin
         r_ack  <= 1'b0;
         r_dat  <= '0;
         r_dll  <= '0;
         r_dlm  <= '0;
         r_ier  <= '0;
         r_lcr  <= 8'h03;
         r_mcr  <= '0;
         r_scr  <= '0;
         r_rbr  <= '0;
         r_thr  <= '0;
         r_iir  <= 8'h01;
         r_lsr  <= 8'h60;
         r_int  <= 1'b0;
         r_thre <= 1'b1;
         r_pend <= 1'b0;
         r_dr   <= 1'b0;
         r_oe   <= 1'b0;
         r_pe   <= 1'b0;
         r_fe   <= 1'b0;
      end else begin
         r_ack <= w_req;
         r_dat <= w_rdata;
         r_iir <= w_iir;
         r_lsr <= w_lsr;
         r_int <= ~w_iir[0];
         if (w_wr) begin
            case (wb_addr_i[2:0])
               3'd0:    if (w_dlab) r_dll <= wb_dat_i;
               3'd1:    if (w_dlab) r_dlm <= wb_dat_i; else r_ier <= wb_dat_i;
               3'd3:    r_lcr <= wb_dat_i;
               3'd4:    r_mcr <= wb_dat_i;
               3'd7:    r_scr <= wb_dat_i;
               default: ;
            endcase
         end
         // Later assignments win: a THR write beats a simultaneous shifter load
         if (w_iir_rd && (r_iir == 8'h02)) r_pend <= 1'b0;
         if (w_tx_load) begin
            r_thre <= 1'b1;
            r_pend <= 1'b1;
         end
         if (w_thr_wr) begin
            r_thr  <= wb_dat_i;
            r_thre <= 1'b0;
            r_pend <= 1'b0;
         end
         if (w_lsr_rd) begin
            r_oe <= 1'b0;
            r_pe <= 1'b0;
            r_fe <= 1'b0;
         end
         if (w_rbr_rd) r_dr <= 1'b0;
         if (w_rx_done) begin
            r_rbr <= w_rx_data;
            r_dr  <= 1'b1;
            if (r_dr && !w_rbr_rd)                  r_oe <= 1'b1;
            if (r_lcr[3] && (r_rx_par != w_par_exp)) r_pe <= 1'b1;
            if (!r_rx_s2)                           r_fe <= 1'b1;
         end
      end
   end

   always_ff @(posedge clock or negedge wb_rst_i) begin
      if (!wb_rst_i) begin
         r_bcnt <= '0;
         r_baud <= 1'b0;
      end else if (w_div == '0) begin
         r_bcnt <= '0;
         r_baud <= 1'b0;
      end else if ((r_bcnt == '0) || (r_bcnt >= w_div)) begin
         r_bcnt <= w_div - 16'd1;
         r_baud <= 1'b1;
      end else begin
         r_bcnt <= r_bcnt - 16'd1;
         r_baud <= 1'b0;
      end
   end

   always_ff @(posedge clock or negedge wb_rst_i) begin
      if (!wb_rst_i) r_tx_st <= S_IDLE;
      else           r_tx_st <= w_tx_nxt;
   end

   always_comb begin
      w_tx_nxt = r_tx_st;
      w_tx_ser = 1'b1;
      case (r_tx_st)
         S_IDLE:  if (w_tx_load) w_tx_nxt = S_START;
         S_START: begin
            w_tx_ser = 1'b0;
            if (w_tx_bend) w_tx_nxt = S_DATA;
         end
         S_DATA: begin
            w_tx_ser = r_tx_shr[0];
            if (w_tx_bend && (r_tx_bit == w_last)) w_tx_nxt = r_lcr[3] ? S_PAR : S_STOP;
         end
         S_PAR: begin
            w_tx_ser = r_tx_par;
            if (w_tx_bend) w_tx_nxt = S_STOP;
         end
         S_STOP:  if (w_tx_bend && (r_tx_bit[0] == r_lcr[2])) w_tx_nxt = S_IDLE;
         default: w_tx_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge wb_rst_i) begin
      if (!wb_rst_i) begin
         r_tx_shr  <= '0;
         r_tx_tick <= '0;
         r_tx_bit  <= '0;
         r_tx_par  <= 1'b0;
         r_stx     <= 1'b1;
      end else begin
         r_stx <= w_loop ? 1'b1 : w_tx_ser;
         if (w_tx_load) begin
            r_tx_shr  <= r_thr;
            r_tx_tick <= '0;
            r_tx_bit  <= '0;
            r_tx_par  <= w_thr_par;
         end else if ((r_tx_st != S_IDLE) && r_baud) begin
            r_tx_tick <= r_tx_tick + 4'd1;
            if (r_tx_tick == 4'hF) begin
               if (r_tx_st == S_DATA) begin
                  r_tx_shr <= r_tx_shr >> 1;
                  r_tx_bit <= (r_tx_bit == w_last) ? 3'd0 : r_tx_bit + 3'd1;
               end else if (r_tx_st == S_STOP) begin
                  r_tx_bit <= r_tx_bit + 3'd1;
               end
            end
         end
      end
   end

   always_ff @(posedge clock or negedge wb_rst_i) begin
      if (!wb_rst_i) r_rx_st <= S_IDLE;
      else           r_rx_st <= w_rx_nxt;
   end

   always_comb begin
      w_rx_nxt = r_rx_st;
      case (r_rx_st)
         S_IDLE:  if (r_rx_s3 && !r_rx_s2) w_rx_nxt = S_START;
         S_START: if (w_rx_smp) w_rx_nxt = r_rx_s2 ? S_IDLE : S_DATA;
         S_DATA:  if (w_rx_smp && (r_rx_bit == w_last)) w_rx_nxt = r_lcr[3] ? S_PAR : S_STOP;
         S_PAR:   if (w_rx_smp) w_rx_nxt = S_STOP;
         S_STOP:  if (w_rx_smp) w_rx_nxt = S_IDLE;
         default: w_rx_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge wb_rst_i) begin
      if (!wb_rst_i) begin
         r_rx_s1   <= 1'b1;
         r_rx_s2   <= 1'b1;
         r_rx_s3   <= 1'b1;
         r_rx_shr  <= '0;
         r_rx_tick <= '0;
         r_rx_bit  <= '0;
         r_rx_par  <= 1'b0;
      end else begin
         r_rx_s1 <= w_rx_in;
         r_rx_s2 <= r_rx_s1;
         r_rx_s3 <= r_rx_s2;
         if (r_rx_st == S_IDLE) begin
            r_rx_tick <= '0;
            r_rx_bit  <= '0;
         end else if (r_baud) begin
            if (w_rx_smp) begin
               r_rx_tick <= '0;
               if (r_rx_st == S_DATA) begin
                  r_rx_shr <= {r_rx_s2, r_rx_shr[7:1]};
                  r_rx_bit <= r_rx_bit + 3'd1;
               end else if (r_rx_st == S_PAR) begin
                  r_rx_par <= r_rx_s2;
               end
            end else begin
               r_rx_tick <= r_rx_tick + 4'd1;
            end
         end
      end
   end

   assign wb_dat_o  = r_dat;
   assign wb_ack_o  = r_ack;
   assign int_o     = r_int;
   assign baud_o    = r_baud;
   assign stx_pad_o = r_stx;
endmodule

// File: tb/tb_uart_modport.sv
// Directed self-checking bench for uart_modport: register map, baud, TX/RX framing, errors, interrupts.
module tb_uart_modport;
   logic       clock = 1'b0;
   logic       wb_rst_i = 1'b0;
   logic [3:0] wb_addr_i = '0;
   logic [3:0] wb_sel_i = '0;
   logic [7:0] wb_dat_i = '0;
   logic       wb_we_i = 1'b0;
   logic       wb_stb_i = 1'b0;
   logic       wb_cyc_i = 1'b0;
   logic [7:0] wb_dat_o;
   logic       wb_ack_o;
   logic       int_o;
   logic       baud_o;
   logic       srx_pad_i = 1'b1;
   logic       stx_pad_o;

   int unsigned n_chk = 0;
   int unsigned n_pass = 0;

   uart_modport dut (
      .clock(clock), .wb_rst_i(wb_rst_i), .wb_addr_i(wb_addr_i), .wb_sel_i(wb_sel_i),
      .wb_dat_i(wb_dat_i), .wb_we_i(wb_we_i), .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i),
      .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .int_o(int_o), .baud_o(baud_o),
      .srx_pad_i(srx_pad_i), .stx_pad_o(stx_pad_o)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic wb_xfer(input logic we, input logic [3:0] adr, input logic [7:0] wd, output logic [7:0] rd);
      int unsigned n;
      @(negedge clock);
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
      wb_addr_i = adr; wb_sel_i = 4'h1; wb_dat_i = wd;
      n = 0;
      do begin
         @(posedge clock); #1; n++;
      end while (!wb_ack_o && n < 8);
      rd = wb_dat_o;
      if (!wb_ack_o) check("wb_ack", {31'd0, wb_ack_o}, 32'd1);
      @(negedge clock);
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
   endtask

   task automatic wb_write(input logic [3:0] adr, input logic [7:0] wd);
      logic [7:0] dummy;
      wb_xfer(1'b1, adr, wd, dummy);
   endtask

   task automatic wb_read_chk(input string tag, input logic [3:0] adr, input logic [7:0] exp);
      logic [7:0] rd;
      wb_xfer(1'b0, adr, 8'h00, rd);
      check(tag, {24'd0, rd}, {24'd0, exp});
   endtask

   task automatic send_frame(input logic [7:0] d, input int unsigned nb, input logic use_par,
                             input logic par, input logic stopv);
      @(negedge clock);
      srx_pad_i = 1'b0;
      repeat (32) @(negedge clock);
      for (int unsigned i = 0; i < nb; i++) begin
         srx_pad_i = d[i];
         repeat (32) @(negedge clock);
      end
      if (use_par) begin
         srx_pad_i = par;
         repeat (32) @(negedge clock);
      end
      srx_pad_i = stopv;
      repeat (32) @(negedge clock);
      srx_pad_i = 1'b1;
      repeat (16) @(negedge clock);
   endtask

   task automatic settle_int(input string tag, input logic exp);
      repeat (3) @(posedge clock);
      #1;
      check(tag, {31'd0, int_o}, {31'd0, exp});
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [9:0] txv;
      logic [5:0] bv;
      logic [2:0] av;
      logic       seen;
      int unsigned pulses;

      repeat (3) @(posedge clock);
      #1;
      check("rst_stx", {31'd0, stx_pad_o}, 32'd1);
      check("rst_int", {31'd0, int_o}, 32'd0);
      check("rst_ack", {31'd0, wb_ack_o}, 32'd0);
      check("rst_baud", {31'd0, baud_o}, 32'd0);
      @(negedge clock);
      wb_rst_i = 1'b1;
      wb_read_chk("rst_rbr", 4'd0, 8'h00);
      wb_read_chk("rst_ier", 4'd1, 8'h00);
      wb_read_chk("rst_iir", 4'd2, 8'h01);
      wb_read_chk("rst_lcr", 4'd3, 8'h03);
      wb_read_chk("rst_mcr", 4'd4, 8'h00);
      wb_read_chk("rst_lsr", 4'd5, 8'h60);
      wb_read_chk("rst_msr", 4'd6, 8'h00);
      wb_read_chk("rst_scr", 4'd7, 8'h00);

      // scratch, address bit 3 and zero byte-select handling
      wb_write(4'd7, 8'h5E);
      wb_read_chk("scr_rw", 4'd7, 8'h5E);
      wb_read_chk("addr8_zero", 4'd15, 8'h00);
      wb_write(4'd15, 8'h11);
      wb_read_chk("addr8_nowrite", 4'd7, 8'h5E);
      @(negedge clock);
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_addr_i = 4'd7; wb_sel_i = 4'h0;
      @(posedge clock); #1;
      check("sel0_ack", {31'd0, wb_ack_o}, 32'd1);
      check("sel0_data", {24'd0, wb_dat_o}, 32'h00);
      @(negedge clock);
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0;

      wb_write(4'd3, 8'h83);
      wb_write(4'd0, 8'h02);
      wb_write(4'd1, 8'h00);
      wb_read_chk("dll_rb", 4'd0, 8'h02);
      wb_write(4'd3, 8'h03);

      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clock); #1;
         if (baud_o) begin seen = 1'b1; break; end
      end
      check("baud_seen", {31'd0, seen}, 32'd1);
      for (int i = 0; i < 6; i++) begin
         @(posedge clock); #1;
         bv[i] = baud_o;
      end
      check("baud_div2", {26'd0, bv}, 32'h2A);

      // held strobe: ack, gap, ack
      @(negedge clock);
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_addr_i = 4'd7; wb_sel_i = 4'h1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clock); #1;
         av[i] = wb_ack_o;
      end
      @(negedge clock);
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
      check("ack_b2b", {29'd0, av}, 32'h5);

      // TX 0xA5, 8N1
      wb_write(4'd1, 8'h02);
      wb_write(4'd0, 8'hA5);
      seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clock); #1;
         if (!stx_pad_o) begin seen = 1'b1; break; end
      end
      check("tx_start_seen", {31'd0, seen}, 32'd1);
      repeat (16) @(posedge clock);
      #1;
      txv[0] = stx_pad_o;
      for (int k = 1; k < 10; k++) begin
         repeat (32) @(posedge clock);
         #1;
         txv[k] = stx_pad_o;
      end
      check("tx_frame_a5", {22'd0, txv}, 32'h34A);
      repeat (40) @(posedge clock);
      wb_read_chk("tx_lsr_temt", 4'd5, 8'h60);
      #1;
      check("tx_int_on", {31'd0, int_o}, 32'd1);
      wb_read_chk("tx_iir_thre", 4'd2, 8'h02);
      settle_int("tx_int_clr", 1'b0);
      wb_read_chk("tx_iir_after", 4'd2, 8'h01);

      // RX 0x3C
      wb_write(4'd1, 8'h01);
      send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b1);
      wb_read_chk("rx_lsr", 4'd5, 8'h61);
      wb_read_chk("rx_iir", 4'd2, 8'h04);
      check("rx_int_on", {31'd0, int_o}, 32'd1);
      wb_read_chk("rx_rbr", 4'd0, 8'h3C);
      settle_int("rx_int_clr", 1'b0);

      // overrun
      wb_write(4'd1, 8'h05);
      send_frame(8'h11, 8, 1'b0, 1'b0, 1'b1);
      send_frame(8'h22, 8, 1'b0, 1'b0, 1'b1);
      wb_read_chk("oe_iir", 4'd2, 8'h06);
      check("oe_int", {31'd0, int_o}, 32'd1);
      wb_read_chk("oe_lsr", 4'd5, 8'h63);
      wb_read_chk("oe_lsr_clr", 4'd5, 8'h61);
      wb_read_chk("oe_iir_dr", 4'd2, 8'h04);
      wb_read_chk("oe_rbr", 4'd0, 8'h22);
      wb_write(4'd1, 8'h00);

      // even parity, 8 bits
      wb_write(4'd3, 8'h1B);
      send_frame(8'h3C, 8, 1'b1, 1'b0, 1'b1);
      wb_read_chk("par_ok_lsr", 4'd5, 8'h61);
      wb_read_chk("par_ok_rbr", 4'd0, 8'h3C);
      send_frame(8'h3C, 8, 1'b1, 1'b1, 1'b1);
      wb_read_chk("par_bad_lsr", 4'd5, 8'h65);
      wb_read_chk("par_bad_rbr", 4'd0, 8'h3C);

      // framing error
      wb_write(4'd3, 8'h03);
      send_frame(8'h55, 8, 1'b0, 1'b0, 1'b0);
      wb_read_chk("fe_lsr", 4'd5, 8'h69);
      wb_read_chk("fe_rbr", 4'd0, 8'h55);

      // 5-bit word
      wb_write(4'd3, 8'h00);
      send_frame(8'h15, 5, 1'b0, 1'b0, 1'b1);
      wb_read_chk("w5_rbr", 4'd0, 8'h15);
      wb_write(4'd3, 8'h03);

      // short low glitch: start bit re-sample aborts
      @(negedge clock);
      srx_pad_i = 1'b0;
      repeat (6) @(negedge clock);
      srx_pad_i = 1'b1;
      repeat (400) @(negedge clock);
      wb_read_chk("glitch_lsr", 4'd5, 8'h60);

`ifdef UART_LOOPBACK_EN
      wb_write(4'd4, 8'h10);
      wb_write(4'd0, 8'h5A);
      seen = 1'b0;
      for (int i = 0; i < 450; i++) begin
         @(posedge clock); #1;
         if (!stx_pad_o) seen = 1'b1;
      end
      check("lb_stx_idle", {31'd0, seen}, 32'd0);
      wb_read_chk("lb_lsr", 4'd5, 8'h61);
      wb_read_chk("lb_rbr", 4'd0, 8'h5A);
      wb_write(4'd4, 8'h00);
`else
      wb_write(4'd4, 8'h10);
      wb_read_chk("mcr_store", 4'd4, 8'h10);
      wb_write(4'd0, 8'h5A);
      seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clock); #1;
         if (!stx_pad_o) begin seen = 1'b1; break; end
      end
      check("mcr_no_loop_tx", {31'd0, seen}, 32'd1);
      repeat (400) @(posedge clock);
      wb_read_chk("mcr_no_loop_lsr", 4'd5, 8'h60);
      wb_write(4'd4, 8'h00);
`endif

      // divisor 0 stops the baud generator
      wb_write(4'd3, 8'h83);
      wb_write(4'd0, 8'h00);
      wb_write(4'd3, 8'h03);
      pulses = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clock); #1;
         if (baud_o) pulses++;
      end
      check("baud_div0", pulses, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/uart_modport.md
# uart_modport

Wishbone-attached UART with a 16550-style register map: 8-bit data bus, 16x-oversampled baud generator, one-byte transmit and receive holding registers, and a single interrupt line. It sits behind the system Wishbone bus as a slave. It serialises host writes onto `stx_pad_o` and deserialises `srx_pad_i` into host-readable data.

## Interface
- No parameters.
- `clock` in 1: system clock; all logic on rising edge.
- `wb_rst_i` in 1: reset, asynchronous, active-low.
- `wb_addr_i` in 4: register address; [2:0] selects the register; accesses with [3]=1 read 0 and ignore writes.
- `wb_sel_i` in 4: byte selects; an access with `wb_sel_i`=0 is acked but has no effect and reads 0.
- `wb_dat_i` in 8: write data.
- `wb_we_i` in 1: 1=write, 0=read.
- `wb_stb_i` in 1: strobe.
- `wb_cyc_i` in 1: bus cycle.
- `wb_dat_o` out 8: read data, valid while `wb_ack_o`=1.
- `wb_ack_o` out 1: single-cycle acknowledge.
- `int_o` out 1: interrupt, active-high.
- `baud_o` out 1: one-clock pulse per 16x baud tick.
- `srx_pad_i` in 1: serial input, asynchronous; idle high.
- `stx_pad_o` out 1: serial output; idle high.

## Operation
Register map. DLAB is `LCR[7]`. Reset values are given in brackets.
- 0: DLAB=0 read RBR / write THR. DLAB=1 DLL [0x00].
- 1: DLAB=0 IER [0x00]: bit0 RX-ready, bit1 THR-empty, bit2 line-status. DLAB=1 DLM [0x00].
- 2: read IIR [0x01]; writes ignored (no FIFOs).
- 3: LCR [0x03]: [1:0] word length 5..8, [2] 2 stop bits, [3] parity enable, [4] even parity, [7] DLAB.
- 4: MCR [0x00]: [4] loopback; other bits storage only.
- 5: LSR [0x60], read-only: [0] DR, [1] OE, [2] PE, [3] FE, [5] THRE, [6] TEMT.
- 6: MSR, reads 0x00.
- 7: SCR [0x00], scratch.

IIR encoding, highest priority first. A cause contributes only if it is enabled in IER.
- Line status (OE|PE|FE): 0x06.
- RX data ready (DR): 0x04.
- THR empty pending: 0x02.
- None: 0x01.
- `int_o` = (IIR[0]==0).

Clear rules:
- Reading LSR clears OE, PE and FE.
- Reading RBR clears DR.
- The THRE-pending flag sets when THR becomes empty. It clears when THR is written, or when IIR is read while it reads 0x02.

Baud generator:
- Free-running counter reloads at divisor {DLM,DLL}-1 and pulses `baud_o` on reload.
- Divisor 0 stops the counter; `baud_o` stays 0.

TX:
- A THR write sets THRE=0.
- When the shifter is idle and THR is full, THR moves into the shifter and THRE=1.
- Frame: start(0), data LSB-first, optional parity, 1 or 2 stop(1). Each bit lasts 16 ticks.
- TEMT=1 when THR and shifter are both empty.

RX:
- `srx_pad_i` passes through a 2-flop synchroniser.
- A falling edge starts a frame. The start bit is re-sampled 8 ticks later; if it is high the frame is aborted.
- Data, parity and stop bits are then sampled every 16 ticks.
- At frame end: RBR is loaded and DR=1. Parity mismatch sets PE; stop bit 0 sets FE.
- If DR was already 1, OE=1 and RBR is overwritten.

## Timing
- Ack: `wb_ack_o`=1 the cycle after `wb_cyc_i&wb_stb_i&!wb_ack_o`, for exactly one cycle.
- Back-to-back strobes therefore ack every other cycle.
- Write side effects and read clears take effect at the ack edge.
- IIR, LSR and `int_o` are registered: they update one cycle after the causing event.
- Reset forces all registers to the values above, `wb_ack_o`=0, `int_o`=0, `baud_o`=0 and `stx_pad_o`=1. Any frame in progress is abandoned.
- A simultaneous RX completion and RBR read: the new byte wins, DR=1, no OE.
- A THR write when THRE=0 overwrites THR and sends no extra frame.

## Configuration
- `UART_LOOPBACK_EN` defined: when `MCR[4]`=1, the TX serial stream feeds the RX synchroniser internally, `stx_pad_o` is held 1 and `srx_pad_i` is ignored.
- `UART_LOOPBACK_EN` undefined: `MCR[4]` is storage only and has no effect.

## Test plan
- Reset, then read addresses 0..7 → 0x00, 0x00, 0x01, 0x03, 0x00, 0x60, 0x00, 0x00; `int_o`=0, `stx_pad_o`=1.
- Write LCR=0x83, DLL=0x02, DLM=0x00, LCR=0x03 → `baud_o` pulses every 2 clocks; each ack is exactly one cycle.
- Write THR=0xA5 → `stx_pad_o` sends 0, 1,0,1,0,0,1,0,1, 1 at 32 clocks/bit. TEMT=1 after the stop bit; with IER=0x02, IIR=0x02 and `int_o`=1.
- Drive frame 0x3C on `srx_pad_i` with IER=0x01 → LSR=0x61, IIR=0x04, `int_o`=1. Reading RBR returns 0x3C and drops `int_o`.
- Receive two frames without reading, with IER=0x05 → LSR bit1=1, IIR=0x06. An LSR read clears OE.
- With `UART_LOOPBACK_EN` defined, MCR=0x10 and THR=0x5A → RBR reads 0x5A and `stx_pad_o` stays 1.
